sprite_loader: RTL and testbench

SPRITE_LOADER -- requirements
Module: sprite_loader

---
 rtl/sprite_loader.sv | 215 +++++++++++++++++++++
 tb/tb_sprite_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_loader.sv
// sprite_loader
//   Streams packed RGB444 pixels from a 32-bit beat interface into the sprite
//   BRAM write port. Each beat carries two pixels: [11:0] is written first,
//   then [27:16]. A small beat FIFO decouples the stream from the write side,
//   which emits one pixel per cycle whenever the FIFO holds data.
//
//   Optional feature: define SPRITE_LOADER_CHECKSUM_EN to build a 16-bit
//   wrapping sum of every written pixel. Without it, checksum is tied to 0.
//
// Parameters
//   ram_add_width  BRAM address width (also the width of length)
//   FIFO_DEPTH     beat FIFO depth, power of two, >= 2
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   start     in   single-cycle upload request (accepted only when idle)
//   abort     in   cancel an upload in progress
//   base_add  in   BRAM address of the first pixel
//   length    in   number of pixels to write
//   s_data    in   packed pixel beat
//   s_valid   in   beat valid
//   s_ready   out  beat accepted when s_valid && s_ready
//   wr_req    out  BRAM write strobe
//   wr_add    out  BRAM write address
//   wr_data   out  BRAM write pixel
//   busy      out  upload in progress (LOAD or DONE)
//   done      out  single-cycle completion pulse
//   error     out  sticky: start while busy, or abort during an upload
//   checksum  out  pixel checksum (0 unless SPRITE_LOADER_CHECKSUM_EN)

module sprite_loader #(
  parameter int ram_add_width = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ram_add_width-1:0] base_add,
  input  logic [ram_add_width-1:0] length,
  input  logic [31:0]              s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     wr_req,
  output logic [ram_add_width-1:0] wr_add,
  output logic [11:0]              wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [15:0]              checksum
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                   state;
  logic [23:0]              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [PTR_W:0]           fifo_count;
  logic [ram_add_width-1:0] base_r;
  logic [ram_add_width-1:0] len_r;
  logic [ram_add_width-1:0] beats_need;
  logic [ram_add_width-1:0] beats_acc;
  logic [ram_add_width-1:0] pix_cnt;
  logic                     half;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        flush;
  logic        pop_pixel;
  logic        pop_beat;
  logic        last_pixel;
  logic [11:0] cur_pixel;
  logic [23:0] head_beat;
  logic        unused_bits;

  // Only the two 12-bit pixel fields of a beat are stored.
  assign unused_bits = ^{s_data[31:28], s_data[15:12]};

  assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign s_ready    = (state == LOAD) && !fifo_full && (beats_acc < beats_need);
  assign push       = s_valid && s_ready;
  assign flush      = (state == LOAD) && abort;

  // A pixel leaves the FIFO head every cycle it holds data; the beat is
  // retired after its high pixel, or after its low pixel when that pixel
  // is the last one of an odd-length upload (high half is dropped).
  assign head_beat  = fifo_mem[rd_ptr];
  assign cur_pixel  = half ? head_beat[23:12] : head_beat[11:0];
  assign last_pixel = ((pix_cnt + ram_add_width'(1)) == len_r);
  assign pop_pixel  = (state == LOAD) && !fifo_empty && !abort && (pix_cnt != len_r);
  assign pop_beat   = pop_pixel && (half || last_pixel);

  // Beat storage; no reset needed because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {s_data[27:16], s_data[11:0]};
    end
  end

  // FIFO pointers and occupancy; an abort empties the FIFO at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)     wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_beat) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop_beat)      fifo_count <= fifo_count + (PTR_W+1)'(1);
      else if (!push && pop_beat) fifo_count <= fifo_count - (PTR_W+1)'(1);
    end
  end

  // Control FSM with registered write port and status outputs. DONE is
  // entered the cycle after the last pixel strobe so done follows the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      base_r     <= '0;
      len_r      <= '0;
      beats_need <= '0;
      beats_acc  <= '0;
      pix_cnt    <= '0;
      half       <= 1'b0;
      wr_req     <= 1'b0;
      wr_add     <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wr_req <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error      <= 1'b0;
            base_r     <= base_add;
            len_r      <= length;
            beats_need <= (length >> 1) + ram_add_width'(length[0]);
            beats_acc  <= '0;
            pix_cnt    <= '0;
            half       <= 1'b0;
            busy       <= 1'b1;
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            if (start) error <= 1'b1;
            if (push)  beats_acc <= beats_acc + ram_add_width'(1);
            if (pix_cnt == len_r) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (pop_pixel) begin
              wr_req  <= 1'b1;
              wr_add  <= base_r + pix_cnt;
              wr_data <= cur_pixel;
              pix_cnt <= pix_cnt + ram_add_width'(1);
              half    <= !pop_beat;
            end
          end
        end
        DONE: begin
          if (start) error <= 1'b1;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [15:0] checksum_r;

  // Sums each pixel as it is presented on the write port; holds after done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_r <= '0;
    end else if ((state == IDLE) && start) begin
      checksum_r <= '0;
    end else if (wr_req) begin
      checksum_r <= checksum_r + {4'b0000, wr_data};
    end
  end

  assign checksum = checksum_r;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_sprite_loader.sv
// tb_sprite_loader
//   Directed bench for sprite_loader: upload timing, odd-length discard,
//   address wrap, zero-length, abort, start-while-busy, stalled stream and
//   mid-upload reset. Write strobes, handshakes and done pulses are logged
//   at the falling edge and compared against hand-computed values.

module tb_sprite_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] base_add;
  logic [15:0] length;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        wr_req;
  logic [15:0] wr_add;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] checksum;

  int checks = 0;
  int fails  = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [15:0] wq_add[$];
  logic [11:0] wq_data[$];
  logic [15:0] exp_sum;
  logic [11:0] exp_a_data[4] = '{12'h123, 12'hABC, 12'h456, 12'hFFF};

  sprite_loader #(.ram_add_width(16), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .base_add (base_add),
    .length   (length),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .wr_req   (wr_req),
    .wr_add   (wr_add),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  // Log write strobes, handshakes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (reset && wr_req) begin
      wq_add.push_back(wr_add);
      wq_data.push_back(wr_data);
    end
    if (reset && s_valid && s_ready) hs_cnt++;
    if (reset && done) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab, input logic sv,
                               input logic [31:0] d, input int cycles);
    start   = st;
    abort   = ab;
    s_valid = sv;
    s_data  = d;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic clearLog();
    wq_add.delete();
    wq_data.delete();
    hs_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " s_ready"},  s_ready,  0);
    checkOutput({tag, " wr_req"},   wr_req,   0);
    checkOutput({tag, " wr_add"},   wr_add,   0);
    checkOutput({tag, " wr_data"},  wr_data,  0);
    checkOutput({tag, " busy"},     busy,     0);
    checkOutput({tag, " done"},     done,     0);
    checkOutput({tag, " error"},    error,    0);
    checkOutput({tag, " checksum"}, checksum, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    fails++;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    base_add = '0; length = '0; s_data = '0; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);

    // Four-pixel upload at 0x100.
    $display("[TB] four-pixel upload");
    clearLog();
    base_add = 16'h0100; length = 16'd4;
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("A busy", busy, 1);
    checkOutput("A s_ready", s_ready, 1);
    applyStimulus(0, 0, 1, 32'h0ABC0123, 1);
    checkOutput("A no early wr_req", wr_req, 0);
    applyStimulus(0, 0, 1, 32'h0FFF0456, 1);
    checkOutput("A first wr_req", wr_req, 1);
    checkOutput("A first wr_add", wr_add, 16'h0100);
    checkOutput("A first wr_data", wr_data, 12'h123);
    applyStimulus(0, 0, 0, 0, 3);
    checkOutput("A last wr_add", wr_add, 16'h0103);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("A done", done, 1);
    checkOutput("A wr_req after last", wr_req, 0);
    checkOutput("A busy in done", busy, 1);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    exp_sum = 16'h0123 + 16'h0ABC + 16'h0456 + 16'h0FFF;
`else
    exp_sum = 16'h0000;
`endif
    checkOutput("A checksum", checksum, exp_sum);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("A done cleared", done, 0);
    checkOutput("A busy cleared", busy, 0);
    checkOutput("A write count", wq_add.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("A wr_add[%0d]", i), wq_add[i], 32'h100 + i);
      checkOutput($sformatf("A wr_data[%0d]", i), wq_data[i], exp_a_data[i]);
    end
    checkOutput("A done pulses", done_cnt, 1);

    // Odd length: high pixel of the last beat dropped, third beat refused.
    $display("[TB] odd-length upload");
    clearLog();
    base_add = 16'h0200; length = 16'd3;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'h00020001, 1);
    applyStimulus(0, 0, 1, 32'h00040003, 1);
    applyStimulus(0, 0, 1, 32'h00060005, 2);
    checkOutput("B s_ready after need", s_ready, 0);
    checkOutput("B third wr_data", wr_data, 12'h003);
    applyStimulus(0, 0, 1, 32'h00060005, 1);
    checkOutput("B done after last write", done, 1);
    checkOutput("B wr_req with done", wr_req, 0);
    applyStimulus(0, 0, 0, 0, 2);
    checkOutput("B handshakes", hs_cnt, 2);
    checkOutput("B write count", wq_data.size(), 3);
    checkOutput("B wr_data[0]", wq_data[0], 12'h001);
    checkOutput("B wr_data[1]", wq_data[1], 12'h002);
    checkOutput("B wr_data[2]", wq_data[2], 12'h003);
    checkOutput("B wr_add[2]", wq_add[2], 16'h0202);
    checkOutput("B done pulses", done_cnt, 1);

    // Address wrap past the top of the BRAM.
    $display("[TB] address wrap");
    clearLog();
    base_add = 16'hFFFF; length = 16'd2;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'h00BB00AA, 1);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("C write count", wq_add.size(), 2);
    checkOutput("C wr_add[0]", wq_add[0], 16'hFFFF);
    checkOutput("C wr_add[1]", wq_add[1], 16'h0000);
    checkOutput("C wr_data[1]", wq_data[1], 12'h0BB);
    checkOutput("C done pulses", done_cnt, 1);

    // Zero length, with abort during DONE having no effect.
    $display("[TB] zero-length upload");
    clearLog();
    base_add = 16'h0000; length = 16'd0;
    applyStimulus(1, 0, 1, 32'h00110022, 1);
    checkOutput("D done next cycle", done, 1);
    checkOutput("D busy", busy, 1);
    checkOutput("D s_ready", s_ready, 0);
    applyStimulus(0, 1, 1, 32'h00110022, 1);
    checkOutput("D done one cycle", done, 0);
    checkOutput("D abort in done error", error, 0);
    checkOutput("D busy cleared", busy, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("D handshakes", hs_cnt, 0);
    checkOutput("D write count", wq_add.size(), 0);

    // Abort after two pixels of an eight-pixel upload.
    $display("[TB] abort");
    clearLog();
    base_add = 16'h0400; length = 16'd8;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'h00020001, 1);
    applyStimulus(0, 0, 1, 32'h00040003, 1);
    applyStimulus(0, 0, 1, 32'h00060005, 1);
    checkOutput("E second wr_data", wr_data, 12'h002);
    applyStimulus(0, 1, 1, 32'h00080007, 1);
    checkOutput("E wr_req after abort", wr_req, 0);
    checkOutput("E s_ready after abort", s_ready, 0);
    checkOutput("E error", error, 1);
    checkOutput("E busy", busy, 0);
    applyStimulus(0, 0, 1, 32'h00080007, 10);
    checkOutput("E write count", wq_add.size(), 2);
    checkOutput("E done pulses", done_cnt, 0);
    checkOutput("E error sticky", error, 1);
    clearLog();
    base_add = 16'h0500; length = 16'd2;
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("E start clears error", error, 0);
    applyStimulus(1, 0, 1, 32'h00220011, 1);
    checkOutput("E start while busy", error, 1);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("E2 write count", wq_add.size(), 2);
    checkOutput("E2 wr_data[1]", wq_data[1], 12'h022);
    checkOutput("E2 wr_add[1]", wq_add[1], 16'h0501);
    checkOutput("E2 done pulses", done_cnt, 1);
    checkOutput("E2 error still set", error, 1);

    // Stream stalled for ten cycles mid-upload.
    $display("[TB] stalled stream");
    clearLog();
    base_add = 16'h0600; length = 16'd4;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'h00B200B1, 1);
    applyStimulus(0, 0, 0, 0, 10);
    checkOutput("F wr_req while empty", wr_req, 0);
    checkOutput("F writes during stall", wq_add.size(), 2);
    checkOutput("F busy during stall", busy, 1);
    applyStimulus(0, 0, 1, 32'h00B400B3, 1);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("F write count", wq_add.size(), 4);
    checkOutput("F wr_data[3]", wq_data[3], 12'h0B4);
    checkOutput("F wr_add[3]", wq_add[3], 16'h0603);
    checkOutput("F done pulses", done_cnt, 1);

    // Reset pulsed mid-upload.
    $display("[TB] reset mid-upload");
    clearLog();
    base_add = 16'h0700; length = 16'd8;
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 32'h00020001, 1);
    applyStimulus(0, 0, 1, 32'h00040003, 1);
    checkOutput("G wr_req before reset", wr_req, 1);
    #3;
    reset = 1'b0;
    #1;
    checkAllZero("G in reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    clearLog();
    applyStimulus(0, 0, 1, 32'h00060005, 10);
    checkOutput("G writes after reset", wq_add.size(), 0);
    checkOutput("G handshakes after reset", hs_cnt, 0);
    checkOutput("G busy after reset", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
